// File: rtl/mig_rd_pkg.sv
// ---------------------------------------------------------------------------
// mig_rd_pkg : shared types and helpers for the MIG native-port read engine
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mig_rd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] CMD_READ = 3'b001;

  // Bytes covered by one burst: (bl+1) words shifted by log2(bytes per word).
  function automatic logic [31:0] burst_bytes(input logic [5:0] bl, input int unsigned byte_sh);
    return ({26'd0, bl} + 32'd1) << byte_sh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mig_addr_wrap.sv
// ---------------------------------------------------------------------------
// mig_addr_wrap : persistent burst byte address with wrap back to INIT_ADDR
// Revision      : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mig_addr_wrap
  import mig_rd_pkg::*;
#(
  parameter int unsigned AW        = 30,
  parameter int unsigned DW        = 32,
  parameter int unsigned INIT_ADDR = 0,
  parameter int unsigned MAX_ADDR  = 2048
) (
  input  logic          clk_i,
  input  logic          init_i,
  input  logic          adv_i,
  input  logic [5:0]    bl_i,
  output logic [AW-1:0] addr_o
);

  localparam int unsigned    BYTE_SH = $clog2(DW / 8);
  localparam logic [AW-1:0]  INIT_A  = AW'(INIT_ADDR);
  localparam logic [AW-1:0]  MAX_A   = AW'(MAX_ADDR);

  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] inc_w, sum_w;

  assign inc_w = AW'(burst_bytes(bl_i, BYTE_SH));
  assign sum_w = addr_q + inc_w;

  // A burst that would reach the boundary is never split; restart at INIT_ADDR.
  always_comb begin
    addr_d = addr_q;
    if (adv_i) begin
      addr_d = (sum_w >= MAX_A) ? INIT_A : sum_w;
    end
  end

  always_ff @(posedge clk_i) begin
    if (init_i) begin
      addr_q <= INIT_A;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

`default_nettype wire

// File: rtl/mig_rd_burst_engine.sv
// ---------------------------------------------------------------------------
// mig_rd_burst_engine : multi-burst read engine for the Spartan-6 MIG p3 port
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mig_rd_burst_engine
  import mig_rd_pkg::*;
#(
  parameter int unsigned AW        = 30,
  parameter int unsigned DW        = 32,
  parameter int unsigned INIT_ADDR = 0,
  parameter int unsigned MAX_ADDR  = 2048,
  parameter int unsigned NB_W      = 8
) (
  input  logic            sclk_i,
  input  logic            rst_n_i,
  input  logic            rd_start_i,
  input  logic [5:0]      rd_cmd_bl_i,
  input  logic [NB_W-1:0] rd_bursts_i,
  input  logic            cmd_full_i,
  input  logic [6:0]      rd_count_i,
  input  logic [DW-1:0]   rd_data_i,
  input  logic            mig_rd_overflow_i,
  input  logic            mig_rd_error_i,
  output logic            cmd_en_o,
  output logic [2:0]      cmd_instr_o,
  output logic [5:0]      cmd_bl_o,
  output logic [AW-1:0]   cmd_byte_addr_o,
  output logic            rd_en_o,
  output logic [DW-1:0]   user_data_o,
  output logic            user_valid_o,
  output logic            busy_o,
  output logic            user_rd_end_o,
  output logic            rd_err_o
);

  state_e          state_q, state_d;
  logic [5:0]      bl_q, bl_d;
  logic [NB_W-1:0] bursts_q, bursts_d;
  logic [6:0]      cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            end_q, end_d;
  logic            err_q, err_d;
  logic            valid_q;
  logic [DW-1:0]   data_q;
  logic            cmd_en_w, rd_en_w, adv_w, flag_w;

  assign flag_w = mig_rd_overflow_i | mig_rd_error_i;

  always_ff @(posedge sclk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      bl_q     <= '0;
      bursts_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      end_q    <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      bl_q     <= bl_d;
      bursts_q <= bursts_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      end_q    <= end_d;
      err_q    <= err_d;
      valid_q  <= rd_en_w;
      if (rd_en_w) begin
        data_q <= rd_data_i;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    bl_d     = bl_q;
    bursts_d = bursts_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    end_d    = 1'b0;
    err_d    = err_q | flag_w;
    cmd_en_w = 1'b0;
    rd_en_w  = 1'b0;
    adv_w    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // end_q blocks a restart in the same cycle the completion pulse is visible.
        if (rd_start_i && (rd_bursts_i != '0) && !end_q) begin
          bl_d     = rd_cmd_bl_i;
          bursts_d = rd_bursts_i;
          err_d    = flag_w;
          busy_d   = 1'b1;
          cnt_d    = '0;
          state_d  = ST_CMD;
        end
      end
      ST_CMD: begin
        if (!cmd_full_i) begin
          cmd_en_w = 1'b1;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (rd_count_i >= ({1'b0, bl_q} + 7'd1)) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        rd_en_w = 1'b1;
        if (cnt_q == {1'b0, bl_q}) begin
          cnt_d    = '0;
          adv_w    = 1'b1;
          bursts_d = bursts_q - NB_W'(1);
          state_d  = (bursts_q == NB_W'(1)) ? ST_DONE : ST_CMD;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_DONE: begin
        end_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  mig_addr_wrap #(
    .AW       (AW),
    .DW       (DW),
    .INIT_ADDR(INIT_ADDR),
    .MAX_ADDR (MAX_ADDR)
  ) u_addr (
    .clk_i (sclk_i),
    .init_i(~rst_n_i),
    .adv_i (adv_w),
    .bl_i  (bl_q),
    .addr_o(cmd_byte_addr_o)
  );

  assign cmd_en_o      = cmd_en_w;
  assign cmd_instr_o   = CMD_READ;
  assign cmd_bl_o      = bl_q;
  assign rd_en_o       = rd_en_w;
  assign user_data_o   = data_q;
  assign user_valid_o  = valid_q;
  assign busy_o        = busy_q;
  assign user_rd_end_o = end_q;
  assign rd_err_o      = err_q;

endmodule

`default_nettype wire

// File: tb/tb_mig_rd_burst_engine.sv
// ---------------------------------------------------------------------------
// tb_mig_rd_burst_engine : directed self-checking bench for mig_rd_burst_engine
// Revision               : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mig_rd_burst_engine;

  localparam int AW   = 30;
  localparam int DW   = 32;
  localparam int NB_W = 8;
  localparam logic [31:0] BASE = 32'hA500_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n, rd_start, cmd_full, ovf, merr;
  logic [5:0]      rd_cmd_bl;
  logic [NB_W-1:0] rd_bursts;
  logic [6:0]      rd_count;
  logic [DW-1:0]   rd_data;
  logic            cmd_en, rd_en, user_valid, busy, user_rd_end, rd_err;
  logic [2:0]      cmd_instr;
  logic [5:0]      cmd_bl;
  logic [AW-1:0]   cmd_byte_addr;
  logic [DW-1:0]   user_data;

  // MIG read FIFO stand-in: each pop presents the next word of an incrementing pattern.
  logic [31:0] pop_cnt = 32'd0;
  always @(posedge clk) if (rd_en) pop_cnt <= pop_cnt + 32'd1;
  assign rd_data = BASE + pop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  mig_rd_burst_engine #(
    .AW(AW), .DW(DW), .INIT_ADDR(0), .MAX_ADDR(2048), .NB_W(NB_W)
  ) dut (
    .sclk_i(clk), .rst_n_i(rst_n), .rd_start_i(rd_start), .rd_cmd_bl_i(rd_cmd_bl),
    .rd_bursts_i(rd_bursts), .cmd_full_i(cmd_full), .rd_count_i(rd_count),
    .rd_data_i(rd_data), .mig_rd_overflow_i(ovf), .mig_rd_error_i(merr),
    .cmd_en_o(cmd_en), .cmd_instr_o(cmd_instr), .cmd_bl_o(cmd_bl),
    .cmd_byte_addr_o(cmd_byte_addr), .rd_en_o(rd_en), .user_data_o(user_data),
    .user_valid_o(user_valid), .busy_o(busy), .user_rd_end_o(user_rd_end), .rd_err_o(rd_err)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) cyc();
    #1;
    n_checks++; if (cmd_en !== 1'b0) begin n_fail++; $display("FAIL rst_cmd_en: got %b want 0", cmd_en); end
    n_checks++; if (cmd_instr !== 3'b001) begin n_fail++; $display("FAIL rst_cmd_instr: got %b want 001", cmd_instr); end
    n_checks++; if (cmd_bl !== 6'd0) begin n_fail++; $display("FAIL rst_cmd_bl: got %0d want 0", cmd_bl); end
    n_checks++; if (cmd_byte_addr !== 30'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", cmd_byte_addr); end
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL rst_rd_en: got %b want 0", rd_en); end
    n_checks++; if (user_data !== 32'd0) begin n_fail++; $display("FAIL rst_user_data: got %h want 0", user_data); end
    n_checks++; if ({user_valid, busy, user_rd_end, rd_err} !== 4'b0000) begin n_fail++; $display("FAIL rst_flags: got %b want 0000", {user_valid, busy, user_rd_end, rd_err}); end
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_single_burst;
    logic [31:0] p0;
    cyc(); rd_cmd_bl = 6'd15; rd_bursts = 8'd1; rd_count = 7'd0; rd_start = 1'b1; #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL s1_busy_pre: got %b want 0", busy); end
    cyc(); rd_start = 1'b0; #1;
    n_checks++; if (cmd_en !== 1'b1) begin n_fail++; $display("FAIL s1_cmd_en: got %b want 1", cmd_en); end
    n_checks++; if (cmd_byte_addr !== 30'd0) begin n_fail++; $display("FAIL s1_cmd_addr: got %0d want 0", cmd_byte_addr); end
    n_checks++; if (cmd_bl !== 6'd15) begin n_fail++; $display("FAIL s1_cmd_bl: got %0d want 15", cmd_bl); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL s1_busy: got %b want 1", busy); end
    cyc(); rd_count = 7'd8; #1;
    n_checks++; if ({cmd_en, rd_en} !== 2'b00) begin n_fail++; $display("FAIL s1_wait_quiet: got %b want 00", {cmd_en, rd_en}); end
    cyc(); rd_count = 7'd16; #1;
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL s1_rd_en_early: got %b want 0", rd_en); end
    cyc(); #1;
    p0 = pop_cnt;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) begin cyc(); #1; end
      n_checks++; if (rd_en !== 1'b1) begin n_fail++; $display("FAIL s1_rd_en[%0d]: got %b want 1", k, rd_en); end
      if (k > 0) begin
        n_checks++;
        if (user_valid !== 1'b1 || user_data !== BASE + p0 + 32'(k - 1)) begin
          n_fail++; $display("FAIL s1_word[%0d]: got v=%b %h want v=1 %h", k - 1, user_valid, user_data, BASE + p0 + 32'(k - 1));
        end
      end
    end
    cyc(); #1;
    n_checks++; if (rd_en !== 1'b0) begin n_fail++; $display("FAIL s1_rd_en_stop: got %b want 0", rd_en); end
    n_checks++; if (user_valid !== 1'b1 || user_data !== BASE + p0 + 32'd15) begin n_fail++; $display("FAIL s1_last_word: got v=%b %h want v=1 %h", user_valid, user_data, BASE + p0 + 32'd15); end
    n_checks++; if ({user_rd_end, busy} !== 2'b01) begin n_fail++; $display("FAIL s1_pre_end: got end,busy=%b want 01", {user_rd_end, busy}); end
    cyc(); rd_start = 1'b1; #1;
    n_checks++; if ({user_rd_end, busy, user_valid} !== 3'b100) begin n_fail++; $display("FAIL s1_end: got end,busy,valid=%b want 100", {user_rd_end, busy, user_valid}); end
    n_checks++; if (cmd_byte_addr !== 30'd64) begin n_fail++; $display("FAIL s1_next_addr: got %0d want 64", cmd_byte_addr); end
    cyc(); rd_start = 1'b0; #1;
    n_checks++; if ({busy, cmd_en, user_rd_end} !== 3'b000) begin n_fail++; $display("FAIL s1_restart_ignored: got busy,cmd_en,end=%b want 000", {busy, cmd_en, user_rd_end}); end
  endtask

  task automatic test_cmd_full;
    bit seen;
    int extra;
    seen = 1'b0; extra = 0;
    cyc(); rd_count = 7'd64; cmd_full = 1'b1; rd_cmd_bl = 6'd15; rd_bursts = 8'd1; rd_start = 1'b1; #1;
    for (int k = 0; k < 5; k++) begin
      cyc(); rd_start = 1'b0; #1;
      n_checks++; if (cmd_en !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL cf_hold[%0d]: got cmd_en=%b busy=%b want 0/1", k, cmd_en, busy); end
    end
    cyc(); cmd_full = 1'b0; #1;
    n_checks++; if (cmd_en !== 1'b1) begin n_fail++; $display("FAIL cf_release: got %b want 1", cmd_en); end
    n_checks++; if (cmd_byte_addr !== 30'd64) begin n_fail++; $display("FAIL cf_addr: got %0d want 64", cmd_byte_addr); end
    cyc(); #1;
    n_checks++; if (cmd_en !== 1'b0) begin n_fail++; $display("FAIL cf_single_pulse: got %b want 0", cmd_en); end
    for (int k = 0; k < 100; k++) begin
      cyc(); #1;
      if (cmd_en) extra++;
      if (user_rd_end) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen || extra != 0) begin n_fail++; $display("FAIL cf_complete: got end=%b extra_cmds=%0d want 1/0", seen, extra); end
    n_checks++; if (cmd_byte_addr !== 30'd128) begin n_fail++; $display("FAIL cf_next_addr: got %0d want 128", cmd_byte_addr); end
  endtask

  task automatic test_ignored_start;
    bit seen;
    int ncmd;
    seen = 1'b0; ncmd = 0;
    cyc(); rd_bursts = 8'd0; rd_cmd_bl = 6'd3; rd_start = 1'b1; #1;
    cyc(); rd_start = 1'b0; #1;
    n_checks++; if ({busy, cmd_en} !== 2'b00) begin n_fail++; $display("FAIL ig_zero_bursts: got busy,cmd_en=%b want 00", {busy, cmd_en}); end
    cyc(); rd_bursts = 8'd2; rd_start = 1'b1; #1;
    cyc(); rd_start = 1'b1; rd_bursts = 8'd5; rd_cmd_bl = 6'd9; #1;
    if (cmd_en) ncmd++;
    for (int k = 0; k < 200; k++) begin
      cyc(); rd_start = 1'b0; #1;
      if (cmd_en) ncmd++;
      if (user_rd_end) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen || ncmd != 2) begin n_fail++; $display("FAIL ig_busy_start: got end=%b cmds=%0d want 1/2", seen, ncmd); end
    n_checks++; if (cmd_bl !== 6'd3) begin n_fail++; $display("FAIL ig_bl_kept: got %0d want 3", cmd_bl); end
    n_checks++; if (cmd_byte_addr !== 30'd160) begin n_fail++; $display("FAIL ig_addr: got %0d want 160", cmd_byte_addr); end
    cyc(); #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ig_idle_after: got %b want 0", busy); end
  endtask

  task automatic test_error;
    bit seen;
    seen = 1'b0;
    cyc(); rd_cmd_bl = 6'd7; rd_bursts = 8'd1; rd_start = 1'b1; #1;
    cyc(); rd_start = 1'b0; #1;
    for (int k = 0; k < 20; k++) begin
      cyc(); #1;
      if (rd_en) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL er_drain_reached: got 0 want 1"); end
    cyc(); ovf = 1'b1; #1;
    cyc(); ovf = 1'b0; #1;
    n_checks++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL er_set: got %b want 1", rd_err); end
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cyc(); #1;
      if (user_rd_end) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen || rd_err !== 1'b1) begin n_fail++; $display("FAIL er_sticky_complete: got end=%b err=%b want 1/1", seen, rd_err); end
    n_checks++; if (cmd_byte_addr !== 30'd192) begin n_fail++; $display("FAIL er_addr: got %0d want 192", cmd_byte_addr); end
    cyc(); rd_start = 1'b1; #1;
    cyc(); rd_start = 1'b0; #1;
    n_checks++; if ({rd_err, busy} !== 2'b01) begin n_fail++; $display("FAIL er_clear_on_start: got err,busy=%b want 01", {rd_err, busy}); end
    seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cyc(); #1;
      if (user_rd_end) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen || rd_err !== 1'b0) begin n_fail++; $display("FAIL er_clean_run: got end=%b err=%b want 1/0", seen, rd_err); end
    cyc(); merr = 1'b1; #1;
    cyc(); merr = 1'b0; #1;
    n_checks++; if (rd_err !== 1'b1) begin n_fail++; $display("FAIL er_idle_flag: got %b want 1", rd_err); end
  endtask

  task automatic test_reset_mid;
    bit hit;
    int ncmd;
    logic [AW-1:0] addr2;
    hit = 1'b0; ncmd = 0; addr2 = '0;
    cyc(); rd_cmd_bl = 6'd3; rd_bursts = 8'd4; rd_start = 1'b1; #1;
    for (int k = 0; k < 100; k++) begin
      cyc(); rd_start = 1'b0; #1;
      if (cmd_en) begin ncmd++; if (ncmd == 2) addr2 = cmd_byte_addr; end
      if (ncmd == 2 && rd_en) begin hit = 1'b1; break; end
    end
    n_checks++; if (!hit || addr2 !== 30'd240) begin n_fail++; $display("FAIL rm_burst2: got hit=%b addr=%0d want 1/240", hit, addr2); end
    rst_n = 1'b0;
    cyc(); rst_n = 1'b1; #1;
    n_checks++; if ({cmd_en, rd_en, user_valid, busy, user_rd_end, rd_err} !== 6'd0) begin n_fail++; $display("FAIL rm_flags: got %b want 000000", {cmd_en, rd_en, user_valid, busy, user_rd_end, rd_err}); end
    n_checks++; if (cmd_byte_addr !== 30'd0 || cmd_bl !== 6'd0 || user_data !== 32'd0) begin n_fail++; $display("FAIL rm_values: got addr=%0d bl=%0d data=%h want 0/0/0", cmd_byte_addr, cmd_bl, user_data); end
    cyc(); #1;
    n_checks++; if ({busy, cmd_en, rd_en} !== 3'b000) begin n_fail++; $display("FAIL rm_stays_idle: got %b want 000", {busy, cmd_en, rd_en}); end
  endtask

  task automatic test_wrap;
    logic [AW-1:0] addrs [9];
    logic [AW-1:0] exp_a;
    bit seen;
    int n;
    seen = 1'b0; n = 0;
    for (int i = 0; i < 9; i++) addrs[i] = '1;
    cyc(); rd_count = 7'd64; rd_cmd_bl = 6'd63; rd_bursts = 8'd9; rd_start = 1'b1; #1;
    for (int k = 0; k < 1000; k++) begin
      cyc(); rd_start = 1'b0; #1;
      if (cmd_en) begin if (n < 9) addrs[n] = cmd_byte_addr; n++; end
      if (user_rd_end) begin seen = 1'b1; break; end
    end
    n_checks++; if (!seen || n != 9) begin n_fail++; $display("FAIL wr_cmd_count: got end=%b cmds=%0d want 1/9", seen, n); end
    for (int i = 0; i < 9; i++) begin
      exp_a = (i < 8) ? AW'(i * 256) : '0;
      n_checks++; if (addrs[i] !== exp_a) begin n_fail++; $display("FAIL wr_addr[%0d]: got %0d want %0d", i, addrs[i], exp_a); end
    end
    n_checks++; if (cmd_byte_addr !== 30'd256) begin n_fail++; $display("FAIL wr_final_addr: got %0d want 256", cmd_byte_addr); end
  endtask

  initial begin
    rst_n = 1'b0; rd_start = 1'b0; cmd_full = 1'b0; ovf = 1'b0; merr = 1'b0;
    rd_cmd_bl = 6'd0; rd_bursts = '0; rd_count = 7'd0;
    test_reset();
    test_single_burst();
    test_cmd_full();
    test_ignored_start();
    test_error();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
